// File: rtl/riscv_mc.sv
// riscv_mc: multi-cycle RV32I/RV64I-subset core with one shared memory port.
// Instruction fetch and data access share the port; every access is held
// until mem_ready completes it.
//
// Ports
//   clk        : clock, rising-edge
//   reset      : asynchronous reset, active low
//   mem_req    : memory transfer request (FETCH, MEM states)
//   mem_we     : 1 = write, 0 = read
//   mem_addr   : byte address (pc in FETCH, rs1+imm in MEM)
//   mem_wdata  : store data (rs2)
//   mem_ready  : memory completes the transfer this cycle
//   mem_rdata  : read data; instruction in bits [31:0]
//   pc         : current instruction address
//   halted     : core stopped on an illegal instruction or misaligned target
//
// Supported: add sub and or slt addi ld/sd (lw/sw for XLEN=32) beq bne jal.
// XLEN must be 32 or 64.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | request instruction at pc, latch it on mem_ready
// S_DECODE | read rs1/rs2, build immediate, reject unsupported encodings
// S_EXEC   | ALU / address / branch resolution
// S_MEM    | load or store transfer at rs1+imm
// S_WB     | write rd, advance pc
// S_HALT   | terminal; only reset leaves it
module riscv_mc #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  // Full-width load/store only: ld/sd on RV64, lw/sw on RV32.
  localparam logic [2:0] F3_LS     = (XLEN == 64) ? 3'b011 : 3'b010;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_res;
  logic [XLEN-1:0] r_daddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_halted;
  logic [XLEN-1:0] r_regs [32];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_f7;
  logic            w_is_r;
  logic            w_is_addi;
  logic            w_is_ls;
  logic            w_is_br;
  logic            w_is_jal;
  logic            w_legal;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_slt;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_misalign;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  assign w_is_r    = (w_opcode == OP_R) &&
                     (((w_f7 == 7'b0000000) &&
                       ((w_f3 == 3'b000) || (w_f3 == 3'b111) ||
                        (w_f3 == 3'b110) || (w_f3 == 3'b010))) ||
                      ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
  assign w_is_addi = (w_opcode == OP_IMM) && (w_f3 == 3'b000);
  assign w_is_ls   = ((w_opcode == OP_LOAD) || (w_opcode == OP_STORE)) &&
                     (w_f3 == F3_LS);
  assign w_is_br   = (w_opcode == OP_BRANCH) &&
                     ((w_f3 == 3'b000) || (w_f3 == 3'b001));
  assign w_is_jal  = (w_opcode == OP_JAL);
  assign w_legal   = w_is_r | w_is_addi | w_is_ls | w_is_br | w_is_jal;

  always_comb begin
    w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    case (w_opcode)
      OP_STORE:  w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      OP_BRANCH: w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7],
                          r_ir[30:25], r_ir[11:8], 1'b0};
      OP_JAL:    w_imm = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12],
                          r_ir[20], r_ir[30:21], 1'b0};
      default:   ;
    endcase
  end

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  assign w_slt = $signed(r_a) < $signed(r_b);

  // Non-R opcodes (addi, load/store address) all need rs1+imm.
  always_comb begin
    w_alu = r_a + r_imm;
    if (w_opcode == OP_R) begin
      case (w_f3)
        3'b000:  w_alu = w_f7[5] ? (r_a - r_b) : (r_a + r_b);
        3'b111:  w_alu = r_a & r_b;
        3'b110:  w_alu = r_a | r_b;
        3'b010:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  assign w_pc4      = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign w_target   = r_pc + r_imm;
  // funct3[0] distinguishes bne from beq.
  assign w_taken    = (r_a == r_b) ^ w_f3[0];
  assign w_misalign = (w_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_res    <= '0;
      r_daddr  <= '0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= mem_rdata[31:0];
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_imm;
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_EXEC: begin
          case (w_opcode)
            OP_BRANCH: begin
              if (w_taken && w_misalign) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc    <= w_taken ? w_target : w_pc4;
                r_state <= S_FETCH;
              end
            end
            OP_JAL: begin
              if (w_misalign) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end else begin
                r_res   <= w_pc4;
                r_state <= S_WB;
              end
            end
            OP_LOAD, OP_STORE: begin
              r_daddr <= w_alu;
              r_wdata <= r_b;
              r_state <= S_MEM;
            end
            default: begin
              r_res   <= w_alu;
              r_state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_opcode == OP_STORE) begin
              r_pc    <= w_pc4;
              r_state <= S_FETCH;
            end else begin
              r_res   <= mem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (w_rd != 5'd0) r_regs[w_rd] <= r_res;
          r_pc    <= (w_opcode == OP_JAL) ? w_target : w_pc4;
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // Port controls decode straight from the registered state so the first
  // fetch is on the bus as soon as reset releases; gating with reset makes
  // an aborted transfer disappear in the same cycle reset is asserted.
  assign mem_req   = reset && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_we    = reset && (r_state == S_MEM) && (w_opcode == OP_STORE);
  assign mem_addr  = !reset ? '0 : ((r_state == S_FETCH) ? r_pc : r_daddr);
  assign mem_wdata = r_wdata;
  assign pc        = r_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_riscv_mc.sv
module tb_riscv_mc;

  localparam int OP_I  = 7'h13;
  localparam int OP_LD = 7'h03;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  logic        clk;
  logic        rst64, rst32;
  logic        rdy64, rdy32;
  logic        m64_req, m64_we, halt64;
  logic [63:0] m64_addr, m64_wdata, m64_rdata, pc64;
  logic        m32_req, m32_we, halt32;
  logic [31:0] m32_addr, m32_wdata, m32_rdata, pc32;

  logic [63:0] mem64 [256];
  logic [31:0] mem32 [256];
  logic        pk_en, pk_sel;
  logic [7:0]  pk_a;
  logic [31:0] pk_d;

  wr_t q64[$];
  wr_t q32[$];
  wr_t e64, e32;
  int  n_checks;
  int  n_err;

  riscv_mc #(.XLEN(64)) dut64 (
    .clk(clk), .reset(rst64), .mem_req(m64_req), .mem_we(m64_we),
    .mem_addr(m64_addr), .mem_wdata(m64_wdata), .mem_ready(rdy64),
    .mem_rdata(m64_rdata), .pc(pc64), .halted(halt64)
  );

  riscv_mc #(.XLEN(32)) dut32 (
    .clk(clk), .reset(rst32), .mem_req(m32_req), .mem_we(m32_we),
    .mem_addr(m32_addr), .mem_wdata(m32_wdata), .mem_ready(rdy32),
    .mem_rdata(m32_rdata), .pc(pc32), .halted(halt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m64_rdata = mem64[m64_addr[9:2]];
  assign m32_rdata = mem32[m32_addr[9:2]];

  // Memory: bench pokes and DUT stores, one word slot per 4-byte address.
  always @(posedge clk) begin
    if (pk_en) begin
      if (pk_sel) mem32[pk_a] <= pk_d;
      else        mem64[pk_a] <= {32'h0, pk_d};
    end
    if (rst64 && m64_req && m64_we && rdy64) mem64[m64_addr[9:2]] <= m64_wdata;
    if (rst32 && m32_req && m32_we && rdy32) mem32[m32_addr[9:2]] <= m32_wdata;
  end

  // Scoreboard: each completed write is matched against the next expected one.
  always @(negedge clk) begin
    if (rst64 && m64_req && m64_we && rdy64) begin
      n_checks++;
      assert (q64.size() != 0) else begin
        n_err++;
        $error("FAIL wr64_unexpected got=%h/%h exp=none", m64_addr, m64_wdata);
      end
      if (q64.size() != 0) begin
        e64 = q64.pop_front();
        assert (m64_addr === e64.a && m64_wdata === e64.d) else begin
          n_err++;
          $error("FAIL wr64 got=%h/%h exp=%h/%h", m64_addr, m64_wdata, e64.a, e64.d);
        end
      end
    end
    if (rst32 && m32_req && m32_we && rdy32) begin
      n_checks++;
      assert (q32.size() != 0) else begin
        n_err++;
        $error("FAIL wr32_unexpected got=%h/%h exp=none", m32_addr, m32_wdata);
      end
      if (q32.size() != 0) begin
        e32 = q32.pop_front();
        assert ({32'h0, m32_addr} === e32.a && {32'h0, m32_wdata} === e32.d) else begin
          n_err++;
          $error("FAIL wr32 got=%h/%h exp=%h/%h", m32_addr, m32_wdata, e32.a, e32.d);
        end
      end
    end
  end

  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int byte_addr, input logic [31:0] d);
    pk_en  = 1'b1;
    pk_sel = sel;
    pk_a   = byte_addr[9:2];
    pk_d   = d;
    step(1);
    pk_en  = 1'b0;
  endtask

  task automatic exp_wr(input logic sel, input logic [63:0] a, input logic [63:0] d);
    if (sel) q32.push_back('{a: a, d: d});
    else     q64.push_back('{a: a, d: d});
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    pk_en    = 1'b0;
    pk_sel   = 1'b0;
    pk_a     = '0;
    pk_d     = '0;
    rdy64    = 1'b1;
    rdy32    = 1'b1;
    rst64    = 1'b1;
    rst32    = 1'b1;
    #1;
    rst64 = 1'b0;
    rst32 = 1'b0;
    #1;
    chk("rst_pc",     pc64, 64'h0);
    chk("rst_req",    {63'd0, m64_req}, 64'd0);
    chk("rst_we",     {63'd0, m64_we}, 64'd0);
    chk("rst_addr",   m64_addr, 64'h0);
    chk("rst_wdata",  m64_wdata, 64'h0);
    chk("rst_halted", {63'd0, halt64}, 64'd0);

    // RV64 program
    load(0, 'h00, i_t(5, 0, 0, 1, OP_I));
    load(0, 'h04, i_t(-3, 0, 0, 2, OP_I));
    load(0, 'h08, r_t(0, 2, 1, 0, 3));
    load(0, 'h0C, j_t(52, 0));
    load(0, 'h40, s_t(16, 3, 0, 3));
    load(0, 'h44, i_t(16, 0, 3, 4, OP_LD));
    load(0, 'h48, s_t('h100, 4, 0, 3));
    load(0, 'h4C, j_t(-44, 5));
    load(0, 'h20, b_t(-8, 0, 0, 0));
    load(0, 'h18, i_t(7, 0, 0, 6, OP_I));
    load(0, 'h1C, j_t(4, 0));
    load(0, 'h24, s_t('h108, 5, 0, 3));
    load(0, 'h28, r_t(0, 1, 2, 2, 7));
    load(0, 'h2C, r_t('h20, 2, 1, 0, 8));
    load(0, 'h30, r_t(0, 2, 1, 7, 9));
    load(0, 'h34, r_t(0, 2, 1, 6, 10));
    load(0, 'h38, r_t(0, 1, 1, 0, 0));
    load(0, 'h3C, j_t(20, 0));
    load(0, 'h50, s_t('h110, 7, 0, 3));
    load(0, 'h54, s_t('h118, 8, 0, 3));
    load(0, 'h58, s_t('h120, 9, 0, 3));
    load(0, 'h5C, s_t('h128, 10, 0, 3));
    load(0, 'h60, s_t('h130, 0, 0, 3));
    load(0, 'h64, s_t('h138, 6, 0, 3));
    load(0, 'h68, 32'h0000007F);
    exp_wr(0, 64'h10,  64'h2);
    exp_wr(0, 64'h100, 64'h2);
    exp_wr(0, 64'h108, 64'h50);
    exp_wr(0, 64'h110, 64'h1);
    exp_wr(0, 64'h118, 64'h8);
    exp_wr(0, 64'h120, 64'h5);
    exp_wr(0, 64'h128, 64'hFFFF_FFFF_FFFF_FFFD);
    exp_wr(0, 64'h130, 64'h0);
    exp_wr(0, 64'h138, 64'h7);

    // RV32 program
    load(1, 'h00, i_t(-1, 0, 0, 1, OP_I));
    load(1, 'h04, r_t(0, 1, 1, 0, 2));
    load(1, 'h08, r_t(0, 0, 1, 2, 3));
    load(1, 'h0C, s_t('h100, 2, 0, 2));
    load(1, 'h10, s_t('h104, 3, 0, 2));
    load(1, 'h14, 32'h0000007F);
    exp_wr(1, 64'h100, 64'hFFFF_FFFE);
    exp_wr(1, 64'h104, 64'h1);

    rst64 = 1'b1;
    rst32 = 1'b1;
    #1;
    chk("first_fetch_req",  {63'd0, m64_req}, 64'd1);
    chk("first_fetch_addr", m64_addr, 64'h0);

    step(12); chk("pc_after_3_alu", pc64, 64'h0C);
    step(4);  chk("pc_jal",         pc64, 64'h40);
    step(4);  chk("pc_store",       pc64, 64'h44);
    step(4);  chk("pc_load_busy",   pc64, 64'h44);
    step(1);  chk("pc_load_done",   pc64, 64'h48);

    rdy64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_addr", m64_addr, 64'h48);
      chk("stall_req",  {63'd0, m64_req}, 64'd1);
      chk("stall_pc",   pc64, 64'h48);
    end
    rdy64 = 1'b1;
    step(4);  chk("pc_after_stall", pc64, 64'h4C);

    step(4);  chk("pc_jal_back",   pc64, 64'h20);
    step(3);  chk("pc_beq_taken",  pc64, 64'h18);
    load(0, 'h20, b_t(-8, 0, 0, 1));
    step(3);  chk("pc_addi_0x18",  pc64, 64'h1C);
    step(4);  chk("pc_jal_fwd",    pc64, 64'h20);
    step(3);  chk("pc_bne_not",    pc64, 64'h24);
    step(52); chk("pc_before_ill", pc64, 64'h68);

    step(2);
    chk("ill_halted", {63'd0, halt64}, 64'd1);
    chk("ill_req",    {63'd0, m64_req}, 64'd0);
    step(5);
    chk("halt_hold",    {63'd0, halt64}, 64'd1);
    chk("halt_req",     {63'd0, m64_req}, 64'd0);
    chk("halt_pc_hold", pc64, 64'h68);

    rst64 = 1'b0;
    #1;
    chk("rst2_halted", {63'd0, halt64}, 64'd0);
    chk("rst2_pc",     pc64, 64'h0);

    // Store aborted by reset while waiting on memory
    load(0, 'h000, i_t(9, 0, 0, 1, OP_I));
    load(0, 'h004, s_t('h140, 1, 0, 3));
    load(0, 'h140, 32'h0000DEAD);
    rst64 = 1'b1;
    step(4); chk("p2_pc_addi", pc64, 64'h4);
    step(1);
    rdy64 = 1'b0;
    step(2);
    chk("p2_mem_req",   {63'd0, m64_req}, 64'd1);
    chk("p2_mem_we",    {63'd0, m64_we}, 64'd1);
    chk("p2_mem_addr",  m64_addr, 64'h140);
    chk("p2_mem_wdata", m64_wdata, 64'h9);
    step(2);
    chk("p2_addr_hold", m64_addr, 64'h140);
    chk("p2_pc_hold",   pc64, 64'h4);
    #2;
    rst64 = 1'b0;
    #1;
    chk("abort_req",   {63'd0, m64_req}, 64'd0);
    chk("abort_we",    {63'd0, m64_we}, 64'd0);
    chk("abort_addr",  m64_addr, 64'h0);
    chk("abort_wdata", m64_wdata, 64'h0);
    step(1);
    chk("abort_no_write", mem64[8'h50], 64'h0000_0000_0000_DEAD);

    // Misaligned jal target
    load(0, 'h000, j_t(2, 1));
    rdy64 = 1'b1;
    rst64 = 1'b1;
    step(3);
    chk("misalign_halted", {63'd0, halt64}, 64'd1);
    chk("misalign_pc",     pc64, 64'h0);

    chk("rv32_halted",  {63'd0, halt32}, 64'd1);
    chk("rv32_pc",      {32'd0, pc32}, 64'h14);
    chk("q64_drained",  64'(q64.size()), 64'd0);
    chk("q32_drained",  64'(q32.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mc.md
RISCV_MC -- requirements
Module: riscv_mc

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/register/address width; legal values 32 and 64 only.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port mem_req  output  1  memory transfer request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 SHALL have port mem_addr  output  XLEN  byte address; valid while mem_req=1.
REQ-008 SHALL have port mem_wdata  output  XLEN  store data; valid while mem_req=1 and mem_we=1.
REQ-009 SHALL have port mem_ready  input  1  memory completes the transfer this cycle.
REQ-010 SHALL have port mem_rdata  input  XLEN  read data, valid when mem_ready=1; instruction in bits [31:0].
REQ-011 SHALL have port pc  output  XLEN  current instruction address.
REQ-012 SHALL have port halted  output  1  core stopped on an illegal instruction.

Function
REQ-013 SHALL be a multi-cycle core sharing one memory port for fetch and data, FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 SHALL complete a transfer only in a cycle with mem_req=1 and mem_ready=1; mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable until then.
REQ-015 SHALL support add, sub, and, or, slt (R-type), addi, load, store, beq, bne, jal; load/store width = XLEN (funct3 011 for XLEN=64, 010 for XLEN=32).
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on completion latch mem_rdata[31:0] into instruction register -> DECODE.
REQ-017 DECODE: read rs1/rs2, build sign-extended immediate; unsupported opcode/funct3/funct7 -> HALT; otherwise -> EXEC.
REQ-018 EXEC: ALU result; R-type/addi/jal -> WB; load/store -> MEM with address rs1+imm; beq/bne -> FETCH.
REQ-019 MEM: load -> read, latch mem_rdata on completion -> WB; store -> write rs2 to address -> pc+=4 -> FETCH.
REQ-020 WB: write rd (jal writes pc+4), update pc (pc+4, or pc+imm for jal) -> FETCH.
REQ-021 branches SHALL set pc=pc+imm when taken, pc+4 otherwise, at the EXEC edge.
REQ-022 a taken branch or jal whose target has bits [1:0] != 0 SHALL go to HALT with pc unchanged.
REQ-023 zero-wait latencies: branch 3, store 4, ALU/jal 4, load 5 cycles.
REQ-024 x0 SHALL read 0; writes with rd=0 SHALL be discarded.
REQ-025 arithmetic SHALL wrap modulo 2^XLEN; slt SHALL be signed compare yielding 0 or 1.
REQ-026 HALT SHALL be terminal: halted=1, mem_req=0, no register/pc updates until reset.
REQ-027 pc SHALL wrap from 2^XLEN-4 to 0 without error.

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) force state FETCH, pc=RESET_PC, mem_req=0, mem_we=0, halted=0, x1..x31=0, mem_addr=0, mem_wdata=0.
REQ-029 reset asserted mid-transfer SHALL abort it; mem_req SHALL drop in the same cycle and no register/memory side effect of that instruction SHALL occur.
REQ-030 first fetch SHALL request RESET_PC in the first clock edge after reset deasserts.

Verification
REQ-031 XLEN=64, mem_ready=1: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 -> x3=2, pc=12 after 12 cycles.
REQ-032 sd x3,16(x0) then ld x4,16(x0) -> write at addr 16 with wdata 2; x4=2; load takes 5 cycles.
REQ-033 mem_ready held 0 for 3 cycles during fetch -> mem_addr stable, no state advance; completes on 4th cycle.
REQ-034 beq x0,x0,-8 at pc=0x20 -> pc=0x18 after 3 cycles; bne x0,x0 -> pc=0x24.
REQ-035 opcode 0x7F fetched -> halted=1 after DECODE, mem_req stays 0; reset=0 -> halted=0, pc=RESET_PC.
REQ-036 XLEN=32: addi x1,x0,-1; add x2,x1,x1 -> x2=0xFFFFFFFE; slt x3,x1,x0 -> x3=1.
